// File: rtl/cnnip_pkg.sv
// ---------------------------------------------------------------------------
// cnnip_pkg
// Types and constants shared by the CNN IP memory arbiter files.
//   port_e          : identifies a requester (H = host bus path, E = conv engine)
//   rd_tag_t        : one stage of the read-return tag pipeline {vld, port}
//   MAX_MEM_LATENCY : largest BRAM read latency the tag pipeline is sized for
// ---------------------------------------------------------------------------
package cnnip_pkg;

  localparam int MAX_MEM_LATENCY = 4;

  typedef enum logic {
    PORT_H = 1'b0,
    PORT_E = 1'b1
  } port_e;

  typedef struct packed {
    logic  vld;
    port_e port;
  } rd_tag_t;

endpackage

// File: rtl/cnnip_mem_arb_if.sv
// ---------------------------------------------------------------------------
// cnnip_mem_arb_if
// Bundles the two requester ports (H, E) and the BRAM port of the arbiter.
//   h_* / e_*  : req, we, addr, din in; gnt, dout, rvalid out (arbiter view)
//   mem_*      : en, we, addr, din out; dout in (arbiter view)
//
// Handshake: a requester holds req (with we/addr/din) until it sees gnt in
// the same cycle; req && gnt is the one and only transfer point, after which
// the requester may change everything. gnt is combinational from req. Read
// data comes back later as a single-cycle rvalid pulse with dout, and only
// on the port that issued the read; there is no backpressure on rvalid.
// ---------------------------------------------------------------------------
interface cnnip_mem_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);

  logic                  h_req;
  logic                  h_we;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_din;
  logic                  h_gnt;
  logic [DATA_WIDTH-1:0] h_dout;
  logic                  h_rvalid;

  logic                  e_req;
  logic                  e_we;
  logic [ADDR_WIDTH-1:0] e_addr;
  logic [DATA_WIDTH-1:0] e_din;
  logic                  e_gnt;
  logic [DATA_WIDTH-1:0] e_dout;
  logic                  e_rvalid;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  // Arbiter side
  modport slave (
    input  h_req, h_we, h_addr, h_din,
    input  e_req, e_we, e_addr, e_din,
    input  mem_dout,
    output h_gnt, h_dout, h_rvalid,
    output e_gnt, e_dout, e_rvalid,
    output mem_en, mem_we, mem_addr, mem_din
  );

  // Requester / memory side
  modport master (
    output h_req, h_we, h_addr, h_din,
    output e_req, e_we, e_addr, e_din,
    output mem_dout,
    input  h_gnt, h_dout, h_rvalid,
    input  e_gnt, e_dout, e_rvalid,
    input  mem_en, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/cnnip_rr_arb2.sv
// ---------------------------------------------------------------------------
// cnnip_rr_arb2
// Two-way round-robin grant between H and E.
//   clk_a, arstz_aq      : clock, async active-low reset
//   h_req_i, e_req_i     : requests
//   h_gnt_o, e_gnt_o     : combinational one-hot (or zero) grant
//   gnt_port_o           : granted port (PORT_H when nothing is granted)
//   last_o               : last granted port, for observation
// `last` resets to PORT_E so H wins the first conflict.
// ---------------------------------------------------------------------------
module cnnip_rr_arb2
  import cnnip_pkg::*;
(
  input  logic  clk_a,
  input  logic  arstz_aq,
  input  logic  h_req_i,
  input  logic  e_req_i,
  output logic  h_gnt_o,
  output logic  e_gnt_o,
  output port_e gnt_port_o,
  output port_e last_o
);

  port_e last_q, last_d;

  always_comb begin
    h_gnt_o = 1'b0;
    e_gnt_o = 1'b0;
    last_d  = last_q;
    if (h_req_i && e_req_i) begin
      // Conflict: the port that did not win last time goes now.
      if (last_q == PORT_E) h_gnt_o = 1'b1;
      else                  e_gnt_o = 1'b1;
    end else if (h_req_i) begin
      h_gnt_o = 1'b1;
    end else if (e_req_i) begin
      e_gnt_o = 1'b1;
    end
    if (h_gnt_o)      last_d = PORT_H;
    else if (e_gnt_o) last_d = PORT_E;
    gnt_port_o = e_gnt_o ? PORT_E : PORT_H;
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) last_q <= PORT_E;
    else           last_q <= last_d;
  end

  assign last_o = last_q;

endmodule

// File: rtl/cnnip_mem_arb.sv
// ---------------------------------------------------------------------------
// cnnip_mem_arb
// Shares one single-port BRAM between the host path (H) and the convolution
// engine controller (E). At most one access per cycle; read data is routed
// back to the issuing port using a tag pipeline that tracks the BRAM latency.
//   clk_a, arstz_aq : clock, async active-low reset
//   bus             : requester ports and BRAM port (cnnip_mem_arb_if.slave)
//   err_ovl         : sticky tag-pipeline overflow flag (never expected)
//   dbg_last_o      : current round-robin `last` register
// Timing: grant at t, BRAM strobe at t+1, mem_dout at t+1+LATENCY,
// rvalid/dout at t+2+LATENCY.
// ---------------------------------------------------------------------------
module cnnip_mem_arb
  import cnnip_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic           clk_a,
  input  logic           arstz_aq,
  cnnip_mem_arb_if.slave bus,
  output logic           err_ovl,
  output port_e          dbg_last_o
);

  // Out-of-range latencies are clamped to the supported range.
  localparam int LAT_C = (LATENCY > MAX_MEM_LATENCY) ? MAX_MEM_LATENCY :
                         (LATENCY < 1)               ? 1 : LATENCY;

  logic                  h_gnt, e_gnt, gnt;
  port_e                 gnt_port;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;

  logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  rd_tag_t [LAT_C:0]     tag_q, tag_d;
  logic [DATA_WIDTH-1:0] h_dout_q, h_dout_d, e_dout_q, e_dout_d;
  logic                  h_rvalid_q, h_rvalid_d, e_rvalid_q, e_rvalid_d;
  logic                  err_q, err_d;
  logic                  retire, all_vld;
  port_e                 ret_port;

  cnnip_rr_arb2 u_arb (
    .clk_a      (clk_a),
    .arstz_aq   (arstz_aq),
    .h_req_i    (bus.h_req),
    .e_req_i    (bus.e_req),
    .h_gnt_o    (h_gnt),
    .e_gnt_o    (e_gnt),
    .gnt_port_o (gnt_port),
    .last_o     (dbg_last_o)
  );

  assign gnt       = h_gnt | e_gnt;
  assign bus.h_gnt = h_gnt;
  assign bus.e_gnt = e_gnt;

  // Command mux from the granted port.
  always_comb begin
    sel_we   = bus.h_we;
    sel_addr = bus.h_addr;
    sel_din  = bus.h_din;
    if (gnt_port == PORT_E) begin
      sel_we   = bus.e_we;
      sel_addr = bus.e_addr;
      sel_din  = bus.e_din;
    end
  end

  always_comb begin
    mem_en_d   = gnt;
    mem_we_d   = gnt & sel_we;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (gnt) begin
      mem_addr_d = sel_addr;
      mem_din_d  = sel_din;
    end

    // The last tag stage lines up with mem_dout for the read it describes.
    retire   = tag_q[LAT_C].vld;
    ret_port = tag_q[LAT_C].port;

    // Shift every cycle; stage 0 takes the new read (if any).
    tag_d         = '0;
    tag_d[0].vld  = gnt & ~sel_we;
    tag_d[0].port = gnt_port;
    for (int i = 1; i <= LAT_C; i++) tag_d[i] = tag_q[i-1];

    all_vld = 1'b1;
    for (int i = 0; i <= LAT_C; i++) all_vld = all_vld & tag_q[i].vld;

    h_rvalid_d = retire && (ret_port == PORT_H);
    e_rvalid_d = retire && (ret_port == PORT_E);
    h_dout_d   = h_rvalid_d ? bus.mem_dout : h_dout_q;
    e_dout_d   = e_rvalid_d ? bus.mem_dout : e_dout_q;

    err_d = err_q | (gnt & ~sel_we & all_vld & ~retire);
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      tag_q      <= '0;
      h_dout_q   <= '0;
      e_dout_q   <= '0;
      h_rvalid_q <= 1'b0;
      e_rvalid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      tag_q      <= tag_d;
      h_dout_q   <= h_dout_d;
      e_dout_q   <= e_dout_d;
      h_rvalid_q <= h_rvalid_d;
      e_rvalid_q <= e_rvalid_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_en   = mem_en_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.h_dout   = h_dout_q;
  assign bus.e_dout   = e_dout_q;
  assign bus.h_rvalid = h_rvalid_q;
  assign bus.e_rvalid = e_rvalid_q;
  assign err_ovl      = err_q;

endmodule

// File: tb/tb_cnnip_mem_arb.sv
`timescale 1ns/1ps
module tb_cnnip_mem_arb;
  import cnnip_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 12;
  localparam int NDUT = 2;   // instance 0: LATENCY=1, instance 1: LATENCY=3

  // ---------------- clock / reset ----------------
  logic clk_a    = 1'b0;
  logic arstz_aq = 1'b1;
  always #5 clk_a = ~clk_a;

  int cyc = 0;
  always @(posedge clk_a) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- shared requester drive ----------------
  logic          h_req = 1'b0, h_we = 1'b0, e_req = 1'b0, e_we = 1'b0;
  logic [AW-1:0] h_addr = '0, e_addr = '0;
  logic [DW-1:0] h_din = '0, e_din = '0;
  logic          drain_chk = 1'b0;

  // ---------------- observed outputs per instance ----------------
  logic          o_h_gnt [NDUT];
  logic          o_e_gnt [NDUT];
  logic          o_h_rvalid [NDUT];
  logic          o_e_rvalid [NDUT];
  logic [DW-1:0] o_h_dout [NDUT];
  logic [DW-1:0] o_e_dout [NDUT];
  logic          o_mem_en [NDUT];
  logic          o_mem_we [NDUT];
  logic [AW-1:0] o_mem_addr [NDUT];
  logic [DW-1:0] o_mem_din [NDUT];
  logic          o_err [NDUT];
  port_e         o_last [NDUT];

  task automatic chk(input string name, input int dut, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h (cycle %0d)", name, dut, act, exp, cyc);
    end
  endtask

  // ---------------- DUT instances, memory models, scoreboards ----------------
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;

    cnnip_mem_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    logic  err_ovl;
    port_e dbg_last;

    cnnip_mem_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(L)) dut (
      .clk_a      (clk_a),
      .arstz_aq   (arstz_aq),
      .bus        (bus),
      .err_ovl    (err_ovl),
      .dbg_last_o (dbg_last)
    );

    assign bus.h_req  = h_req;
    assign bus.h_we   = h_we;
    assign bus.h_addr = h_addr;
    assign bus.h_din  = h_din;
    assign bus.e_req  = e_req;
    assign bus.e_we   = e_we;
    assign bus.e_addr = e_addr;
    assign bus.e_din  = e_din;

    assign o_h_gnt[g]    = bus.h_gnt;
    assign o_e_gnt[g]    = bus.e_gnt;
    assign o_h_rvalid[g] = bus.h_rvalid;
    assign o_e_rvalid[g] = bus.e_rvalid;
    assign o_h_dout[g]   = bus.h_dout;
    assign o_e_dout[g]   = bus.e_dout;
    assign o_mem_en[g]   = bus.mem_en;
    assign o_mem_we[g]   = bus.mem_we;
    assign o_mem_addr[g] = bus.mem_addr;
    assign o_mem_din[g]  = bus.mem_din;
    assign o_err[g]      = err_ovl;
    assign o_last[g]     = dbg_last;

    // BRAM model: read data appears L cycles after the strobe edge.
    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] rd_pipe [L];
    always @(posedge clk_a) begin
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
      rd_pipe[0] <= mem[bus.mem_addr];
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_dout = rd_pipe[L-1];

    // Reference model: memory contents as seen in grant order, expected
    // returns in issue order with their due cycle.
    logic [DW-1:0] shadow [0:4095];
    logic [DW-1:0] exp_q [$];
    int            due_q [$];
    port_e         port_q [$];
    port_e         last_m;
    logic          pend_en, pend_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic          eh, ee, gw;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;

    initial begin
      for (int i = 0; i < 4096; i++) begin
        mem[i]    = '0;
        shadow[i] = '0;
      end
      mem[12'h300]    = 32'hDEADBEEF;
      shadow[12'h300] = 32'hDEADBEEF;
      for (int i = 0; i < L; i++) rd_pipe[i] = '0;
    end

    always @(negedge clk_a) begin
      if (!arstz_aq) begin
        last_m  = PORT_E;
        pend_en = 1'b0;
        pend_we = 1'b0;
        m_addr  = '0;
        m_din   = '0;
        exp_q.delete();
        due_q.delete();
        port_q.delete();
      end else begin
        // Round-robin rule: a lone requester wins; on conflict the port
        // other than the last winner wins.
        eh = h_req && (!e_req || last_m == PORT_E);
        ee = e_req && !eh;
        chk("h_gnt", g, bus.h_gnt, eh);
        chk("e_gnt", g, bus.e_gnt, ee);
        chk("mem_en", g, bus.mem_en, pend_en);
        chk("mem_we", g, bus.mem_we, pend_we);
        chk("mem_addr", g, bus.mem_addr, m_addr);
        chk("mem_din", g, bus.mem_din, m_din);
        chk("err_ovl", g, err_ovl, 0);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          chk("h_rvalid", g, bus.h_rvalid, port_q[0] == PORT_H);
          chk("e_rvalid", g, bus.e_rvalid, port_q[0] == PORT_E);
          if (port_q[0] == PORT_H) chk("h_dout", g, bus.h_dout, exp_q[0]);
          else                     chk("e_dout", g, bus.e_dout, exp_q[0]);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
          void'(port_q.pop_front());
        end else begin
          chk("h_rvalid_idle", g, bus.h_rvalid, 0);
          chk("e_rvalid_idle", g, bus.e_rvalid, 0);
        end
        if (drain_chk) chk("drain_pending", g, due_q.size(), 0);

        pend_en = eh || ee;
        gw      = eh ? h_we : e_we;
        ga      = eh ? h_addr : e_addr;
        gd      = eh ? h_din : e_din;
        pend_we = pend_en && gw;
        if (pend_en) begin
          m_addr = ga;
          m_din  = gd;
          last_m = eh ? PORT_H : PORT_E;
          if (gw) shadow[ga] = gd;
          else begin
            exp_q.push_back(shadow[ga]);
            due_q.push_back(cyc + 2 + L);
            port_q.push_back(eh ? PORT_H : PORT_E);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic hr, input logic hw, input logic [AW-1:0] ha,
                       input logic [DW-1:0] hd, input logic er, input logic ew,
                       input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    @(posedge clk_a);
    #1;
    h_req = hr; h_we = hw; h_addr = ha; h_din = hd;
    e_req = er; e_we = ew; e_addr = ea; e_din = ed;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'(12'h300 + 4 * $urandom_range(0, 7));
  endfunction

  task automatic check_reset_vals(input string tag);
    for (int g = 0; g < NDUT; g++) begin
      chk({tag, "_h_gnt"}, g, o_h_gnt[g], 0);
      chk({tag, "_e_gnt"}, g, o_e_gnt[g], 0);
      chk({tag, "_mem_en"}, g, o_mem_en[g], 0);
      chk({tag, "_mem_we"}, g, o_mem_we[g], 0);
      chk({tag, "_mem_addr"}, g, o_mem_addr[g], 0);
      chk({tag, "_mem_din"}, g, o_mem_din[g], 0);
      chk({tag, "_h_dout"}, g, o_h_dout[g], 0);
      chk({tag, "_e_dout"}, g, o_e_dout[g], 0);
      chk({tag, "_h_rvalid"}, g, o_h_rvalid[g], 0);
      chk({tag, "_e_rvalid"}, g, o_e_rvalid[g], 0);
      chk({tag, "_err_ovl"}, g, o_err[g], 0);
      chk({tag, "_last"}, g, o_last[g], PORT_E);
    end
  endtask

  // ---------------- grant table ----------------
  typedef struct {
    logic  hr;
    logic  er;
    logic  exp_h;
    logic  exp_e;
    port_e exp_last;   // `last` register value during that cycle
  } vec_t;
  vec_t vecs [12];

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, PORT_E};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, PORT_E};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, PORT_E};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, PORT_E};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, PORT_E};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, PORT_H};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, PORT_E};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, PORT_H};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, PORT_H};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, PORT_E};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, PORT_E};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, PORT_H};

    // Reset
    #1 arstz_aq = 1'b0;
    #1 check_reset_vals("rst");
    repeat (2) @(posedge clk_a);
    #1 arstz_aq = 1'b1;

    // Grant table: E alone 4 cycles, then conflicts from last=E
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].hr, 1'b0, AW'(12'h100 + 4 * i), '0,
            vecs[i].er, 1'b0, AW'(12'h200 + 4 * i), '0);
      @(negedge clk_a);
      for (int g = 0; g < NDUT; g++) begin
        chk("tbl_h_gnt", g, o_h_gnt[g], vecs[i].exp_h);
        chk("tbl_e_gnt", g, o_e_gnt[g], vecs[i].exp_e);
        chk("tbl_last", g, o_last[g], vecs[i].exp_last);
      end
    end
    repeat (8) idle();

    // Single H read of 0x300
    drive(1'b1, 1'b0, 12'h300, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk_a);
    for (int g = 0; g < NDUT; g++) chk("rd300_gnt", g, o_h_gnt[g], 1);
    for (int k = 1; k <= 6; k++) begin
      idle();
      @(negedge clk_a);
      for (int g = 0; g < NDUT; g++) begin
        lat = (g == 0) ? 1 : 3;
        if (k == 1) begin
          chk("rd300_mem_en", g, o_mem_en[g], 1);
          chk("rd300_mem_addr", g, o_mem_addr[g], 12'h300);
        end
        chk("rd300_h_rvalid", g, o_h_rvalid[g], k == 2 + lat);
        if (k == 2 + lat) chk("rd300_h_dout", g, o_h_dout[g], 32'hDEADBEEF);
        chk("rd300_e_rvalid", g, o_e_rvalid[g], 0);
      end
    end
    repeat (4) idle();

    // Both ports reading continuously: alternation with no idle strobe
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, rand_addr(), '0, 1'b1, 1'b0, rand_addr(), '0);
      @(negedge clk_a);
      for (int g = 0; g < NDUT; g++) begin
        chk("alt_h_gnt", g, o_h_gnt[g], (i % 2) == 1);
        chk("alt_e_gnt", g, o_e_gnt[g], (i % 2) == 0);
        if (i > 0) chk("alt_mem_en", g, o_mem_en[g], 1);
      end
    end
    repeat (8) idle();

    // E writes 0x304, H reads it back in the next granted cycle
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h304, 32'h12345678);
    @(negedge clk_a);
    drive(1'b1, 1'b0, 12'h304, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk_a);
    for (int g = 0; g < NDUT; g++) begin
      chk("wr_mem_we", g, o_mem_we[g], 1);
      chk("wr_mem_addr", g, o_mem_addr[g], 12'h304);
      chk("wr_mem_din", g, o_mem_din[g], 32'h12345678);
    end
    for (int k = 1; k <= 6; k++) begin
      idle();
      @(negedge clk_a);
      for (int g = 0; g < NDUT; g++) begin
        lat = (g == 0) ? 1 : 3;
        if (k == 1) chk("raw_rd_we", g, o_mem_we[g], 0);
        chk("raw_h_rvalid", g, o_h_rvalid[g], k == 2 + lat);
        if (k == 2 + lat) chk("raw_h_dout", g, o_h_dout[g], 32'h12345678);
        chk("raw_e_rvalid", g, o_e_rvalid[g], 0);
      end
    end
    repeat (4) idle();

    // 8 back-to-back mixed accesses from both ports
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
            1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    repeat (8) idle();

    // Random traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    repeat (10) idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    drain_chk = 1'b1;
    @(negedge clk_a);
    idle();
    drain_chk = 1'b0;

    // Reset with two reads in flight
    drive(1'b1, 1'b0, 12'h300, '0, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h304, '0);
    idle();
    @(posedge clk_a);
    #1 arstz_aq = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (2) @(posedge clk_a);
    #1 arstz_aq = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_a);
      for (int g = 0; g < NDUT; g++) begin
        chk("post_rst_h_rvalid", g, o_h_rvalid[g], 0);
        chk("post_rst_e_rvalid", g, o_e_rvalid[g], 0);
      end
    end

    repeat (2) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
